// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared constants and pointer wrap helper for the FIFO read stream adapter
package fifo_rd_pkg;

  // Default data word width, matching the asynchronous FIFO
  localparam int FIFO_W = 4;

  // Default skid depth; 3 entries cover the registered read latency at full rate
  localparam int SKID_DEPTH = 3;

  // Width of the optional statistics counters
  localparam int STAT_W = 16;

  // Advance a circular index, wrapping depth-1 back to 0
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// rtl/rd_skid_buf.sv - circular skid buffer holding words captured from the FIFO read port
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int Width = FIFO_W,
  parameter int DEPTH = SKID_DEPTH,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic [CW-1:0]    count
);

  logic [Width-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  int unsigned      count_next;

  // Occupancy after this cycle, kept wide so an underflow or overflow is visible
  always_comb begin
    count_next = 32'(count) + 32'(push) - 32'(pop);
  end

  // Pointer and occupancy state; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= PW'(ptr_inc(32'(wr_ptr), unsigned'(DEPTH)));
      end
      if (pop) begin
        rd_ptr <= PW'(ptr_inc(32'(rd_ptr), unsigned'(DEPTH)));
      end
      count <= CW'(count_next);
    end
  end

  // Storage is deliberately not reset; the output gate hides stale contents
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Head word, forced to zero whenever the buffer is empty
  always_comb begin
    pop_data = (count != '0) ? mem[rd_ptr] : '0;
  end

  // The issue rule upstream must keep occupancy within the buffer
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_next <= unsigned'(DEPTH));
    end
  end

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// rtl/fifo_rd_stream_adapter.sv - FIFO read port to valid/ready stream adapter; optional FIFO_RD_STATS_EN adds word/stall counters
module fifo_rd_stream_adapter
  import fifo_rd_pkg::*;
#(
  parameter int Width = FIFO_W,
  parameter int DEPTH = SKID_DEPTH
) (
  input  logic              rclk,
  input  logic              r_rst,
  input  logic              fifo_empty,
  output logic              fifo_ren,
  input  logic [Width-1:0]  fifo_rdata,
  output logic              m_valid,
  output logic [Width-1:0]  m_data,
  input  logic              m_ready
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [STAT_W-1:0] word_cnt,
  output logic [STAT_W-1:0] stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  logic          inflight;
  logic          pop;
  logic [CW-1:0] count;

  // Issue a read only when the word still in flight is guaranteed a free slot;
  // depends on registered state only, so m_ready never reaches fifo_ren
  always_comb begin
    fifo_ren = !r_rst && !fifo_empty && ((32'(count) + 32'(inflight)) < unsigned'(DEPTH));
  end

  // A read issued this cycle returns data on the next one
  always_ff @(posedge rclk) begin
    if (r_rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_ren;
    end
  end

  // Stream handshake derived from buffer occupancy
  always_comb begin
    m_valid = (count != '0);
    pop     = m_valid && m_ready;
  end

  rd_skid_buf #(
    .Width (Width),
    .DEPTH (DEPTH)
  ) u_skid (
    .clk       (rclk),
    .rst       (r_rst),
    .push      (inflight),
    .push_data (fifo_rdata),
    .pop       (pop),
    .pop_data  (m_data),
    .count     (count)
  );

`ifdef FIFO_RD_STATS_EN
  // Saturating counters for delivered words and downstream stall cycles
  always_ff @(posedge rclk) begin
    if (r_rst) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop && (word_cnt != {STAT_W{1'b1}})) begin
        word_cnt <= word_cnt + STAT_W'(1);
      end
      if (m_valid && !m_ready && (stall_cnt != {STAT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + STAT_W'(1);
      end
    end
  end
`else
  // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb/tb_fifo_rd_stream_adapter.sv - self-checking bench for fifo_rd_stream_adapter with FIFO model and scoreboard
module tb_fifo_rd_stream_adapter;

  logic       rclk = 1'b0;
  logic       r_rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic       fifo_ren;
  logic [3:0] fifo_rdata = 4'h0;
  logic       m_valid;
  logic [3:0] m_data;
  logic       m_ready = 1'b0;
`ifdef FIFO_RD_STATS_EN
  logic [15:0] word_cnt;
  logic [15:0] stall_cnt;
`endif

  always #5 rclk = ~rclk;

  fifo_rd_stream_adapter #(
    .Width (4),
    .DEPTH (3)
  ) dut (
    .rclk       (rclk),
    .r_rst      (r_rst),
    .fifo_empty (fifo_empty),
    .fifo_ren   (fifo_ren),
    .fifo_rdata (fifo_rdata),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready)
`ifdef FIFO_RD_STATS_EN
    ,
    .word_cnt   (word_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  logic [3:0] fq[$];
  logic [3:0] exp_q[$];

  logic       s_ren;
  logic       s_valid;
  logic [3:0] s_data;
  logic       s_pop;
  int         cyc = 0;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       ren;
    logic       chk;
    logic       vld;
    logic [3:0] dat;
  } vec_t;

  vec_t vt[8];

  int nren, npop, stable, first_pop, last_pop, stalls, ren_cyc, v_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_word(input logic [3:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample mid-cycle, score pops, then model the FIFO's registered read
  task automatic cycle();
    logic [3:0] e;
    @(negedge rclk);
    s_ren   = fifo_ren;
    s_valid = m_valid;
    s_data  = m_data;
    s_pop   = m_valid && m_ready;
    if (fifo_empty || r_rst) check("ren_blocked", 32'(fifo_ren), 32'd0);
    if (s_pop) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 32'(s_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("pop_data", 32'(s_data), 32'(e));
      end
    end
    @(posedge rclk);
    #1;
    cyc++;
    if (s_ren && fq.size() != 0) fifo_rdata = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // reset held 3 cycles with a word waiting, then a single-word transfer
    vt[0] = '{rst: 1'b1, rdy: 1'b1, ren: 1'b0, chk: 1'b0, vld: 1'b0, dat: 4'h0};
    vt[1] = '{rst: 1'b1, rdy: 1'b1, ren: 1'b0, chk: 1'b1, vld: 1'b0, dat: 4'h0};
    vt[2] = '{rst: 1'b1, rdy: 1'b1, ren: 1'b0, chk: 1'b1, vld: 1'b0, dat: 4'h0};
    vt[3] = '{rst: 1'b0, rdy: 1'b1, ren: 1'b1, chk: 1'b1, vld: 1'b0, dat: 4'h0};
    vt[4] = '{rst: 1'b0, rdy: 1'b1, ren: 1'b0, chk: 1'b1, vld: 1'b0, dat: 4'h0};
    vt[5] = '{rst: 1'b0, rdy: 1'b1, ren: 1'b0, chk: 1'b1, vld: 1'b1, dat: 4'hA};
    vt[6] = '{rst: 1'b0, rdy: 1'b1, ren: 1'b0, chk: 1'b1, vld: 1'b0, dat: 4'h0};
    vt[7] = '{rst: 1'b0, rdy: 1'b1, ren: 1'b0, chk: 1'b1, vld: 1'b0, dat: 4'h0};

    push_word(4'hA);
    for (int i = 0; i < 8; i++) begin
      r_rst   = vt[i].rst;
      m_ready = vt[i].rdy;
      cycle();
      check($sformatf("vec%0d_ren", i), 32'(s_ren), 32'(vt[i].ren));
      if (vt[i].chk) begin
        check($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vt[i].vld));
        check($sformatf("vec%0d_data", i), 32'(s_data), 32'(vt[i].dat));
      end
    end

    // backpressure: only three reads fit, head word held stable
    m_ready = 1'b0;
    for (int w = 1; w <= 5; w++) push_word(4'(w));
    nren = 0;
    stable = 0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      nren += int'(s_ren);
      if (s_valid && s_data == 4'h1) stable++;
    end
    check("bp_ren_pulses", 32'(nren), 32'd3);
    check("bp_stable_cycles", 32'(stable), 32'd12);
    m_ready = 1'b1;
    npop = 0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      npop += int'(s_pop);
    end
    check("bp_pops", 32'(npop), 32'd5);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // throughput: eight back-to-back words with no bubble
    for (int w = 1; w <= 8; w++) push_word(4'(w));
    npop = 0;
    first_pop = -1;
    last_pop = -1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (s_pop) begin
        npop++;
        if (first_pop < 0) first_pop = i;
        last_pop = i;
      end
    end
    check("tp_pops", 32'(npop), 32'd8);
    check("tp_first_latency", 32'(first_pop), 32'd2);
    check("tp_contiguous", 32'(last_pop - first_pop), 32'd7);

    // FIFO drains right after a read: in-flight word still delivered
    push_word(4'h9);
    cycle();
    check("ems_ren", 32'(s_ren), 32'd1);
    cycle();
    check("ems_valid_early", 32'(s_valid), 32'd0);
    cycle();
    check("ems_pop", 32'(s_pop), 32'd1);
    for (int i = 0; i < 3; i++) cycle();
    push_word(4'h6);
    push_word(4'h7);
    ren_cyc = -1;
    v_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (s_ren && ren_cyc < 0) ren_cyc = i;
      if (s_valid && v_cyc < 0) v_cyc = i;
    end
    check("ems_resume_ren", 32'(ren_cyc), 32'd0);
    check("ems_resume_latency", 32'(v_cyc - ren_cyc), 32'd2);
    check("ems_drained", 32'(exp_q.size()), 32'd0);

    // reset with two buffered words and one read in flight
    m_ready = 1'b0;
    for (int w = 1; w <= 5; w++) push_word(4'(w));
    for (int i = 0; i < 3; i++) cycle();
    check("rmo_ren_blocked_full", 32'(fifo_ren), 32'd0);
    r_rst = 1'b1;
    cycle();
    check("rmo_ren_in_reset", 32'(s_ren), 32'd0);
    r_rst = 1'b0;
    fq.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    cycle();
    check("rmo_valid", 32'(s_valid), 32'd0);
    check("rmo_data", 32'(s_data), 32'd0);
`ifdef FIFO_RD_STATS_EN
    check("rmo_word_cnt", 32'(word_cnt), 32'd0);
    check("rmo_stall_cnt", 32'(stall_cnt), 32'd0);

    // three pops after four stall cycles
    for (int w = 1; w <= 3; w++) push_word(4'(w + 10));
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (s_valid && !m_ready) stalls++;
      if (stalls == 4) break;
    end
    check("st_stalls_seen", 32'(stalls), 32'd4);
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    check("st_word_cnt", 32'(word_cnt), 32'd3);
    check("st_stall_cnt", 32'(stall_cnt), 32'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
